fetch_queue: RTL and testbench

Instruction fetch queue between `if_stage` and `if_id_reg`. It decouples fetch from decode so that a decode-side stall does not discard instructions already fetched. It buffers up to 2^DEPTH_LOG2 {pc, instr} pairs in order with valid/ready handshakes on both sides. A flush input discards all buffered entries on a control-flow redirect.

---
 rtl/core_pkg.sv | 6 +
 rtl/fetch_queue_mem.sv | 23 ++
 rtl/fetch_queue.sv | 73 +++++++
 tb/tb_fetch_queue.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants used by the fetch path and the decode interface.
package core_pkg;
    localparam int          BUS_WIDTH   = 64;
    localparam int          INSTR_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue_mem.sv
// Register array for the fetch queue: one synchronous write port and one asynchronous read port.
module fetch_queue_mem #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage is deliberately not reset; occupancy tracking decides what is valid.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// In-order {pc, instr} queue between fetch and decode with valid/ready on both sides and flush.
module fetch_queue #(
    parameter int BUS_WIDTH   = core_pkg::BUS_WIDTH,
    parameter int INSTR_WIDTH = core_pkg::INSTR_WIDTH,
    parameter int DEPTH_LOG2  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BUS_WIDTH-1:0]   in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BUS_WIDTH-1:0]   out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [DEPTH_LOG2:0]    count
);
    import core_pkg::NOP_INSTR;

    localparam int                  DATA_W    = BUS_WIDTH + INSTR_WIDTH;
    localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push, w_pop;
    logic [DATA_W-1:0]     w_rdata;

    // Handshake outputs depend only on registered occupancy.
    assign in_ready  = (r_count != CNT_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    fetch_queue_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && !flush),
        .i_waddr (r_wr_ptr),
        .i_wdata ({in_pc, in_instr}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign out_pc    = out_valid ? w_rdata[DATA_W-1:INSTR_WIDTH] : '0;
    assign out_instr = out_valid ? w_rdata[INSTR_WIDTH-1:0] : INSTR_WIDTH'(NOP_INSTR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: occupancy model plus an in-order scoreboard of pushed entries.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [63:0] in_pc, out_pc;
    logic [31:0] in_instr, out_instr;
    logic [2:0]  count;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t sb[$];
    int     m_cnt   = 0;
    int     n_pass  = 0;
    int     n_total = 0;

    fetch_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return 32'hA500_0000 | {16'h0, pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called just after a falling edge: drive inputs, check against the model, advance one cycle.
    task automatic step(input logic v, input logic [63:0] pc, input logic r, input logic f);
        entry_t e;
        bit     push, pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = mk_instr(pc);
        out_ready = r;
        flush     = f;
        #1;
        check("count", {61'd0, count}, 64'(m_cnt));
        check("in_ready", {63'd0, in_ready}, {63'd0, m_cnt != 4});
        check("out_valid", {63'd0, out_valid}, {63'd0, m_cnt != 0});
        if (m_cnt == 0) begin
            check("empty_pc", out_pc, 64'h0);
            check("empty_instr", {32'd0, out_instr}, 64'h13);
        end
        push = v && (m_cnt != 4);
        pop  = r && (m_cnt != 0);
        if (pop) begin
            e = sb.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
        end
        if (f) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            if (push) begin
                e.pc    = pc;
                e.instr = mk_instr(pc);
                sb.push_back(e);
            end
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_cnt > 0 && guard < 16) begin
            step(1'b0, 64'h0, 1'b1, 1'b0);
            guard++;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'h0);
        check("rst_in_ready", {63'd0, in_ready}, 64'h1);
        check("rst_count", {61'd0, count}, 64'h0);
        check("rst_instr", {32'd0, out_instr}, 64'h13);
        @(negedge clk);
        rst = 1'b0;

        // Fill and drain
        for (int k = 0; k < 4; k++) step(1'b1, 64'(4*k), 1'b0, 1'b0);
        step(1'b1, 64'h40, 1'b0, 1'b0);
        drain();
        step(1'b0, 64'h0, 1'b0, 1'b0);

        // Streaming across pointer wrap
        step(1'b1, 64'h100, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) step(1'b1, 64'h100 + 64'(4*k), 1'b1, 1'b0);
        drain();

        // Full with pop, then the held input is accepted
        for (int k = 0; k < 4; k++) step(1'b1, 64'h300 + 64'(4*k), 1'b0, 1'b0);
        step(1'b1, 64'h310, 1'b1, 1'b0);
        step(1'b1, 64'h310, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        drain();

        // Flush with simultaneous push and pop at count 3
        for (int k = 0; k < 3; k++) step(1'b1, 64'h400 + 64'(4*k), 1'b0, 1'b0);
        step(1'b1, 64'h40C, 1'b1, 1'b1);
        step(1'b0, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation at count 2
        step(1'b1, 64'h500, 1'b0, 1'b0);
        step(1'b1, 64'h504, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'h0);
        check("arst_in_ready", {63'd0, in_ready}, 64'h1);
        check("arst_count", {61'd0, count}, 64'h0);
        sb.delete();
        m_cnt = 0;
        #1 rst = 1'b0;
        @(negedge clk);
        step(1'b1, 64'h200, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);

        // Pop on empty queue must not underflow
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b1, 64'h600, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
